axi_lite_sram: RTL and testbench

- AXI-Lite slave memory: the downstream endpoint of the read/write arbiter.
- Owns a word-addressed internal SRAM.
- Serves one outstanding read and one outstanding write at a time, on independent channels.
- Latency per channel is configurable, with optional pseudo-random jitter, so upstream handshake logic is exercised under variable timing.

---
 rtl/axi_lite_pkg.sv | 21 ++
 rtl/axi_lite_sram_lfsr8.sv | 24 ++
 rtl/axi_lite_sram.sv | 244 ++++++++++++++++++++++++
 tb/tb_axi_lite_sram.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions.
// Response codes and channel FSM encodings.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_BUSY = 2'b01,
        R_RESP = 2'b10
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_BUSY = 2'b01,
        W_RESP = 2'b10
    } wr_state_e;

endpackage

// File: rtl/axi_lite_sram_lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4.
// Free-running source of latency jitter.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] q
);

    logic fb;

    assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

    // Shift every cycle, reload the seed on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else begin
            q <= {q[6:0], fb};
        end
    end

endmodule

// File: rtl/axi_lite_sram.sv
// AXI-Lite slave backed by a word-addressed SRAM.
// Independent read/write channels with programmable latency.
module axi_lite_sram
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int          MEM_WORDS = 4096,
    parameter int          RD_LAT    = 2,
    parameter int          WR_LAT    = 2,
    parameter bit          JITTER_EN = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        arvalid_i,
    input  logic [31:0] araddr_i,
    output logic        arready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    input  logic        rready_i,
    input  logic        awvalid_i,
    input  logic [31:0] awaddr_i,
    output logic        awready_o,
    input  logic        wvalid_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic        wready_o,
    output logic        bvalid_o,
    output logic [1:0]  bresp_o,
    input  logic        bready_i
);

    localparam int          IDX_W = $clog2(MEM_WORDS);
    localparam logic [32:0] SPAN  = 33'(MEM_WORDS) << 2;
    localparam logic [32:0] LO    = {1'b0, ADDR_BASE};
    localparam logic [32:0] HI    = LO + SPAN;

    function automatic logic hit_of(input logic [31:0] a);
        return ({1'b0, a} >= LO) && ({1'b0, a} < HI);
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] a);
        return IDX_W'((a - ADDR_BASE) >> 2);
    endfunction

    logic [31:0] mem [MEM_WORDS];

    logic [7:0] lfsr_q;
    logic [4:0] jit;
    logic [4:0] rd_load;
    logic [4:0] wr_load;

    lfsr8 #(.SEED(8'hA5)) u_lfsr (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .q     (lfsr_q)
    );

    assign jit     = JITTER_EN ? 5'(lfsr_q & 8'h03) : 5'd0;
    assign rd_load = 5'(RD_LAT) + jit;
    assign wr_load = 5'(WR_LAT) + jit;

    // ---------------- read channel ----------------
    rd_state_e        rd_state, rd_next;
    logic [4:0]       rd_cnt, rd_cnt_n;
    logic [IDX_W-1:0] rd_idx, rd_idx_n, rd_sidx;
    logic             rd_hit, rd_hit_n, rd_shit;
    logic             rd_sample;
    logic [31:0]      rdata_q;
    logic [1:0]       rresp_q;

    // Read next-state: latch address, count down, sample once.
    always_comb begin
        rd_next   = rd_state;
        rd_cnt_n  = rd_cnt;
        rd_idx_n  = rd_idx;
        rd_hit_n  = rd_hit;
        rd_sample = 1'b0;
        rd_sidx   = rd_idx;
        rd_shit   = rd_hit;
        unique case (rd_state)
            R_IDLE: begin
                if (arvalid_i) begin
                    rd_idx_n = idx_of(araddr_i);
                    rd_hit_n = hit_of(araddr_i);
                    rd_cnt_n = rd_load;
                    if (rd_load == 5'd0) begin
                        rd_sample = 1'b1;
                        rd_sidx   = idx_of(araddr_i);
                        rd_shit   = hit_of(araddr_i);
                        rd_next   = R_RESP;
                    end else begin
                        rd_next = R_BUSY;
                    end
                end
            end
            R_BUSY: begin
                if (rd_cnt <= 5'd1) begin
                    rd_cnt_n  = 5'd0;
                    rd_sample = 1'b1;
                    rd_next   = R_RESP;
                end else begin
                    rd_cnt_n = rd_cnt - 5'd1;
                end
            end
            R_RESP: begin
                if (rready_i) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // Read state and registered response payload.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_state <= R_IDLE;
            rd_cnt   <= 5'd0;
            rd_idx   <= '0;
            rd_hit   <= 1'b0;
            rdata_q  <= 32'd0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            rd_cnt   <= rd_cnt_n;
            rd_idx   <= rd_idx_n;
            rd_hit   <= rd_hit_n;
            if (rd_sample) begin
                rdata_q <= rd_shit ? mem[rd_sidx] : 32'd0;
                rresp_q <= rd_shit ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    assign arready_o = rst_n_i && (rd_state == R_IDLE);
    assign rvalid_o  = (rd_state == R_RESP);
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;

    // ---------------- write channel ----------------
    wr_state_e        wr_state, wr_next;
    logic [4:0]       wr_cnt, wr_cnt_n;
    logic             aw_got, aw_got_n, w_got, w_got_n;
    logic             aw_fire, w_fire;
    logic [IDX_W-1:0] wr_idx, wr_idx_n;
    logic             wr_hit, wr_hit_n;
    logic [31:0]      wdata_q, wdata_n;
    logic [3:0]       wstrb_q, wstrb_n;
    logic [1:0]       bresp_q, bresp_n;
    logic             wr_commit;

    assign aw_fire = (wr_state == W_IDLE) && awvalid_i && !aw_got;
    assign w_fire  = (wr_state == W_IDLE) && wvalid_i && !w_got;

    // Write next-state: gather AW and W, wait, then commit.
    always_comb begin
        wr_next   = wr_state;
        wr_cnt_n  = wr_cnt;
        aw_got_n  = aw_got;
        w_got_n   = w_got;
        wr_idx_n  = wr_idx;
        wr_hit_n  = wr_hit;
        wdata_n   = wdata_q;
        wstrb_n   = wstrb_q;
        bresp_n   = bresp_q;
        wr_commit = 1'b0;
        unique case (wr_state)
            W_IDLE: begin
                if (aw_fire) begin
                    wr_idx_n = idx_of(awaddr_i);
                    wr_hit_n = hit_of(awaddr_i);
                end
                if (w_fire) begin
                    wdata_n = wdata_i;
                    wstrb_n = wstrb_i;
                end
                if ((aw_got || aw_fire) && (w_got || w_fire)) begin
                    aw_got_n = 1'b0;
                    w_got_n  = 1'b0;
                    wr_cnt_n = wr_load;
                    wr_next  = W_BUSY;
                end else begin
                    aw_got_n = aw_got || aw_fire;
                    w_got_n  = w_got || w_fire;
                end
            end
            W_BUSY: begin
                if (wr_cnt <= 5'd1) begin
                    wr_cnt_n  = 5'd0;
                    wr_commit = 1'b1;
                    bresp_n   = wr_hit ? RESP_OKAY : RESP_DECERR;
                    wr_next   = W_RESP;
                end else begin
                    wr_cnt_n = wr_cnt - 5'd1;
                end
            end
            W_RESP: begin
                if (bready_i) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // Write state, capture flags and pending payload.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_state <= W_IDLE;
            wr_cnt   <= 5'd0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            wr_idx   <= '0;
            wr_hit   <= 1'b0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
            bresp_q  <= RESP_OKAY;
        end else begin
            wr_state <= wr_next;
            wr_cnt   <= wr_cnt_n;
            aw_got   <= aw_got_n;
            w_got    <= w_got_n;
            wr_idx   <= wr_idx_n;
            wr_hit   <= wr_hit_n;
            wdata_q  <= wdata_n;
            wstrb_q  <= wstrb_n;
            bresp_q  <= bresp_n;
        end
    end

    // Byte-masked SRAM update; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_commit && wr_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign awready_o = rst_n_i && (wr_state == W_IDLE) && !aw_got;
    assign wready_o  = rst_n_i && (wr_state == W_IDLE) && !w_got;
    assign bvalid_o  = (wr_state == W_RESP);
    assign bresp_o   = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram.sv
// Directed bench for axi_lite_sram.
// Second instance with jitter shares the write channel.
module tb_axi_lite_sram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic [31:0] araddr = 32'd0;
    logic        arready, rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic [31:0] awaddr = 32'd0, wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic        awready, wready, bvalid;
    logic [1:0]  bresp;

    logic        arvalid_j = 1'b0, rready_j = 1'b0;
    logic [31:0] araddr_j = 32'd0;
    logic        arready_j, rvalid_j;
    logic [31:0] rdata_j;
    logic [1:0]  rresp_j;
    logic        awready_j, wready_j, bvalid_j;
    logic [1:0]  bresp_j;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_lite_sram dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .arvalid_i(arvalid), .araddr_i(araddr), .arready_o(arready),
        .rvalid_o(rvalid), .rdata_o(rdata), .rresp_o(rresp),
        .rready_i(rready),
        .awvalid_i(awvalid), .awaddr_i(awaddr), .awready_o(awready),
        .wvalid_i(wvalid), .wdata_i(wdata), .wstrb_i(wstrb),
        .wready_o(wready),
        .bvalid_o(bvalid), .bresp_o(bresp), .bready_i(bready)
    );

    axi_lite_sram #(.JITTER_EN(1'b1)) dutj (
        .clk_i(clk), .rst_n_i(rst_n),
        .arvalid_i(arvalid_j), .araddr_i(araddr_j), .arready_o(arready_j),
        .rvalid_o(rvalid_j), .rdata_o(rdata_j), .rresp_o(rresp_j),
        .rready_i(rready_j),
        .awvalid_i(awvalid), .awaddr_i(awaddr), .awready_o(awready_j),
        .wvalid_i(wvalid), .wdata_i(wdata), .wstrb_i(wstrb),
        .wready_o(wready_j),
        .bvalid_o(bvalid_j), .bresp_o(bresp_j), .bready_i(bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e,
                      input int hold, output logic [31:0] d,
                      output logic [1:0] r, output int lat);
        int n;
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = a;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        d = rdata;
        r = rresp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("r_hold_valid", 64'(rvalid), 64'd1);
            chk("r_hold_data", 64'(rdata), 64'(e));
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic rdj(input logic [31:0] a, input logic [31:0] e,
                       inout int lo, inout int hi);
        int n;
        int lat;
        @(negedge clk);
        arvalid_j = 1'b1;
        araddr_j  = a;
        n = 0;
        while (!arready_j && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        arvalid_j = 1'b0;
        lat = 1;
        while (!rvalid_j && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("jit_lat_range", 64'(lat >= 3 && lat <= 6), 64'd1);
        chk("jit_rdata", 64'(rdata_j), 64'(e));
        if (lat < lo) lo = lat;
        if (lat > hi) hi = lat;
        rready_j = 1'b1;
        @(negedge clk);
        rready_j = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int dly,
                      output logic [1:0] r, output int lat);
        int cyc;
        int n;
        @(negedge clk);
        awvalid = 1'b1;
        awaddr  = a;
        if (dly == 0) begin
            wvalid = 1'b1;
            wdata  = d;
            wstrb  = s;
        end
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        cyc = 1;
        if (dly > 0) begin
            while (cyc < dly) begin
                @(negedge clk);
                cyc++;
            end
            wvalid = 1'b1;
            wdata  = d;
            wstrb  = s;
            @(negedge clk);
            wvalid = 1'b0;
            cyc++;
        end
        while (!bvalid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        lat = cyc;
        r = bresp;
        bready = 1'b1;
        n = 0;
        while (!bvalid_j && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("jit_bvalid_seen", 64'(bvalid_j), 64'd1);
        @(negedge clk);
        bready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        int          cyc;
        int          lo;
        int          hi;
        logic        seen;
        logic [31:0] jv [8];
        int          k;

        #12;
        chk("reset_outputs",
            64'({arready, rvalid, rdata, rresp, awready, wready, bvalid,
                 bresp, arready_j, awready_j, wready_j}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 64'({arready, awready, wready}), 64'h7);

        wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, r, lat);
        chk("wr_same_cycle_lat", 64'(lat), 64'd3);
        chk("wr_bresp_okay", 64'(r), 64'd0);
        wr(32'h8000_0020, 32'hAAAA_BBBB, 4'hF, 0, r, lat);
        wr(32'h8000_0000, 32'h0123_4567, 4'hF, 0, r, lat);

        rd(32'h8000_0010, 32'hDEAD_BEEF, 4, d, r, lat);
        chk("rd_lat", 64'(lat), 64'd3);
        chk("rd_data", 64'(d), 64'hDEAD_BEEF);
        chk("rd_resp", 64'(r), 64'd0);

        wr(32'h8000_0020, 32'h1122_3344, 4'b0101, 3, r, lat);
        chk("wr_split_lat", 64'(lat), 64'd6);
        chk("wr_split_bresp", 64'(r), 64'd0);
        rd(32'h8000_0020, 32'hAA22_BB44, 0, d, r, lat);
        chk("rd_strobe_merge", 64'(d), 64'hAA22_BB44);

        rd(32'h8000_0013, 32'hDEAD_BEEF, 0, d, r, lat);
        chk("rd_low_bits_ignored", 64'(d), 64'hDEAD_BEEF);

        rd(32'h7FFF_FFFC, 32'h0, 0, d, r, lat);
        chk("rd_miss_resp", 64'(r), 64'd3);
        chk("rd_miss_data", 64'(d), 64'd0);
        wr(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0, r, lat);
        chk("wr_miss_bresp", 64'(r), 64'd3);
        rd(32'h8000_0000, 32'h0123_4567, 0, d, r, lat);
        chk("miss_no_alias_write", 64'(d), 64'h0123_4567);

        wr(32'h8000_3FFC, 32'h0BAD_CAFE, 4'hF, 0, r, lat);
        chk("wr_last_word_okay", 64'(r), 64'd0);
        rd(32'h8000_3FFC, 32'h0BAD_CAFE, 0, d, r, lat);
        chk("rd_last_word", 64'({r, d}), 64'h0_0BAD_CAFE);

        wr(32'h8000_0010, 32'h1234_5678, 4'b0000, 0, r, lat);
        chk("wr_zero_strb_okay", 64'(r), 64'd0);
        rd(32'h8000_0010, 32'hDEAD_BEEF, 0, d, r, lat);
        chk("zero_strb_unchanged", 64'(d), 64'hDEAD_BEEF);

        @(negedge clk);
        arvalid = 1'b1;
        araddr  = 32'h8000_0010;
        awvalid = 1'b1;
        awaddr  = 32'h8000_0010;
        wvalid  = 1'b1;
        wdata   = 32'hCAFE_F00D;
        wstrb   = 4'hF;
        @(negedge clk);
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        cyc = 1;
        while (!rvalid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("coll_rd_lat", 64'(cyc), 64'd3);
        chk("coll_bvalid_same", 64'(bvalid), 64'd1);
        chk("coll_old_data", 64'(rdata), 64'hDEAD_BEEF);
        rready = 1'b1;
        bready = 1'b1;
        cyc = 0;
        while (!bvalid_j && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        rready = 1'b0;
        bready = 1'b0;
        rd(32'h8000_0010, 32'hCAFE_F00D, 0, d, r, lat);
        chk("coll_new_data", 64'(d), 64'hCAFE_F00D);

        @(negedge clk);
        arvalid = 1'b1;
        araddr  = 32'h8000_0020;
        awvalid = 1'b1;
        awaddr  = 32'h8000_0020;
        wvalid  = 1'b1;
        wdata   = 32'h5555_5555;
        wstrb   = 4'hF;
        @(negedge clk);
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs",
            64'({arready, rvalid, rdata, rresp, awready, wready, bvalid,
                 bresp}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | rvalid | bvalid | rvalid_j | bvalid_j;
        end
        chk("midrst_no_response", 64'(seen), 64'd0);
        rd(32'h8000_0020, 32'hAA22_BB44, 0, d, r, lat);
        chk("midrst_word_kept", 64'(d), 64'hAA22_BB44);

        for (int i = 0; i < 8; i++) begin
            jv[i] = 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
            wr(32'h8000_0100 + 32'(4 * i), jv[i], 4'hF, 0, r, lat);
        end
        lo = 99;
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            k = int'($urandom_range(0, 7));
            rdj(32'h8000_0100 + 32'(4 * k), jv[k], lo, hi);
        end
        chk("jit_latency_varies", 64'(hi > lo), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
